// File: rtl/sub_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the control-state encoding and default widths.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N  = 8;
  localparam int DEF_CW = 4;

  // Smallest counter width able to index n bit positions.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sub1b.sv
// 1-bit full subtractor cell: Q = A - B - C_wej.
// Ports: A, B, C_wej (borrow-in) -> Q (difference), C_wyj (borrow-out).
module sub1b (
  input  logic A,
  input  logic B,
  input  logic C_wej,
  output logic Q,
  output logic C_wyj
);

  assign Q = A ^ B ^ C_wej;

  // Borrow when the minuend bit cannot cover subtrahend plus borrow-in.
  assign C_wyj = (~A & B) | (~A & C_wej) | (B & C_wej);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock via sub1b.
// Ports: CLK, RST_N, start, A, B, C_wej in; busy, done, Q, C_wyj out.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_wej,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic         C_wyj
);

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sha_q, sha_d;
  logic [N-1:0]  shb_q, shb_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  q_q, q_d;
  logic          bor_q, bor_d;
  logic          cwyj_q, cwyj_d;

  logic          cell_q;
  logic          cell_b;
  logic          last;

  sub1b u_cell (
    .A     (sha_q[0]),
    .B     (shb_q[0]),
    .C_wej (bor_q),
    .Q     (cell_q),
    .C_wyj (cell_b)
  );

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    bor_d   = bor_q;
    q_d     = q_q;
    cwyj_d  = cwyj_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts start too, so held start
        // chains ops without an IDLE gap.
        if (start) begin
          state_d = RUN;
          sha_d   = A;
          shb_d   = B;
          bor_d   = C_wej;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sha_d = sha_q >> 1;
        shb_d = shb_q >> 1;
        // Difference bits enter at the MSB so
        // bit 0 lands at position 0 after N shifts.
        res_d = {cell_q, res_q[N-1:1]};
        bor_d = cell_b;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          q_d     = res_d;
          cwyj_d  = cell_b;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      q_q     <= '0;
      cwyj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      q_q     <= q_d;
      cwyj_q  <= cwyj_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign Q     = q_q;
  assign C_wyj = cwyj_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (N=8).
// Directed vectors, abort, back-to-back and random ops vs. arithmetic model.
module tb_sub_serial;

  localparam int N = 8;

  logic         CLK;
  logic         RST_N;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_wej;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic         C_wyj;

  int checks;
  int errors;
  int cyc;

  sub_serial #(.N(N), .CW(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .A     (A),
    .B     (B),
    .C_wej (C_wej),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .C_wyj (C_wyj)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: plain integer subtraction, wrapped to N bits.
  function automatic logic [N:0] model(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         c
  );
    int d;
    logic [31:0] dv;
    d  = int'(a) - int'(b) - int'(c);
    dv = d;
    return {d < 0, dv[N-1:0]};
  endfunction

  // Issue one op, scramble inputs during RUN, wait for done.
  task automatic do_op(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    output logic [N-1:0] q,
    output logic         bw,
    output int           nb,
    output bit           ok
  );
    q  = '0;
    bw = 1'b0;
    nb = 0;
    ok = 1'b0;
    @(posedge CLK); #1;
    A = a; B = b; C_wej = c; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    A = N'($urandom); B = N'($urandom);
    C_wej = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        q  = Q;
        bw = C_wyj;
        break;
      end
      if (busy) nb++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    start = 1'b0;
    A = '0; B = '0; C_wej = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, Q, C_wyj} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b Q=%h C_wyj=%b want all 0",
               busy, done, Q, C_wyj);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_directed;
    logic [N-1:0] ta [5] = '{8'h5A, 8'h10, 8'hFF, 8'h00, 8'h80};
    logic [N-1:0] tb [5] = '{8'h23, 8'h20, 8'h00, 8'h00, 8'h7F};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] eq [5] = '{8'h37, 8'hF0, 8'hFF, 8'hFF, 8'h00};
    logic         eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] q;
    logic bw;
    int nb;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tc[i], q, bw, nb, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d_timeout: no done within bound", i);
        continue;
      end
      checks++;
      if (nb !== N) begin
        errors++;
        $display("FAIL dir%0d_busy_len: got %0d want %0d", i, nb, N);
      end
      checks++;
      if ({bw, q} !== {eb[i], eq[i]}) begin
        errors++;
        $display("FAIL dir%0d_result: Q=%h C_wyj=%b want Q=%h C_wyj=%b",
                 i, q, bw, eq[i], eb[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int ndone;
    logic [N-1:0] q;
    logic bw;
    ndone = 0;
    q = '0;
    bw = 1'b0;
    @(posedge CLK); #1;
    A = 8'h5A; B = 8'h23; C_wej = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 1; i < 18; i++) begin
      if (i == 3) begin
        start = 1'b1; A = 8'h01; B = 8'h01;
      end else if (i == 4) begin
        start = 1'b0; A = 8'hFF; B = 8'hAA;
      end
      if (done) begin
        ndone++;
        q  = Q;
        bw = C_wyj;
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d want 1", ndone);
    end
    checks++;
    if ({bw, q} !== {1'b0, 8'h37}) begin
      errors++;
      $display("FAIL ignore_result: Q=%h C_wyj=%b want Q=37 C_wyj=0",
               q, bw);
    end
  endtask

  task automatic test_abort;
    logic [N-1:0] q;
    logic bw;
    int nb;
    bit ok;
    @(posedge CLK); #1;
    A = 8'hC3; B = 8'h11; C_wej = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({busy, done, Q, C_wyj} !== '0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b Q=%h C_wyj=%b want all 0",
               busy, done, Q, C_wyj);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    do_op(8'h09, 8'h03, 1'b0, q, bw, nb, ok);
    checks++;
    if (!ok || {bw, q} !== {1'b0, 8'h06}) begin
      errors++;
      $display("FAIL abort_after: ok=%b Q=%h C_wyj=%b want Q=06 C_wyj=0",
               ok, q, bw);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] a1, b1, a2, b2;
    logic c1, c2;
    logic [N:0] e1, e2;
    int t1, t2;
    bit seen;
    a1 = N'($urandom); b1 = N'($urandom); c1 = 1'($urandom);
    a2 = N'($urandom); b2 = N'($urandom); c2 = 1'($urandom);
    e1 = model(a1, b1, c1);
    e2 = model(a2, b2, c2);
    t1 = 0;
    t2 = 0;
    @(posedge CLK); #1;
    A = a1; B = b1; C_wej = c1; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (done) begin
        seen = 1'b1;
        t1 = cyc;
        break;
      end
    end
    checks++;
    if (!seen || {C_wyj, Q} !== e1) begin
      errors++;
      $display("FAIL b2b_first: seen=%b Q=%h C_wyj=%b want Q=%h C_wyj=%b",
               seen, Q, C_wyj, e1[N-1:0], e1[N]);
    end
    A = a2; B = b2; C_wej = c2;
    @(posedge CLK); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b want 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        t2 = cyc;
        break;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    checks++;
    if (!seen || (t2 - t1) !== N + 1) begin
      errors++;
      $display("FAIL b2b_spacing: seen=%b got %0d want %0d",
               seen, t2 - t1, N + 1);
    end
    checks++;
    if ({C_wyj, Q} !== e2) begin
      errors++;
      $display("FAIL b2b_second: Q=%h C_wyj=%b want Q=%h C_wyj=%b",
               Q, C_wyj, e2[N-1:0], e2[N]);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] a, b, q;
    logic c, bw;
    logic [N:0] e;
    int nb;
    bit ok;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      c = 1'($urandom);
      e = model(a, b, c);
      do_op(a, b, c, q, bw, nb, ok);
      checks++;
      if (!ok || {bw, q} !== e) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand%0d: %h-%h-%b got Q=%h C_wyj=%b want Q=%h C_wyj=%b",
                   i, a, b, c, q, bw, e[N-1:0], e[N]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
